// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches on an sram-like port,
// buffers returned instructions in a DEPTH-entry ring and hands {pc,inst} to decode.
module inst_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    input  logic        if_ready,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_wdata,
    input  logic [31:0] inst_rdata,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [XLEN-1:0] WORD_BYTES = 32'd4;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  hold_addr_q, hold_addr_d;
    logic             req_hold_q, req_hold_d;
    logic             hold_stale_q, hold_stale_d;
    logic             running_q;
    logic [PTR_W-1:0] alloc_q, alloc_d;
    logic [PTR_W-1:0] fill_q, fill_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [CNT_W-1:0] used_q, used_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [DEPTH-1:0] filled_q, filled_d;
    logic [XLEN-1:0]  ent_pc_q   [DEPTH];
    logic [XLEN-1:0]  ent_inst_q [DEPTH];

    logic             room;
    logic             addr_hs;
    logic             alloc_en;
    logic             fill_en;
    logic             retire;
    logic [CNT_W-1:0] filled_cnt;
    logic [CNT_W-1:0] unfilled_cnt;

    assign inst_wr    = 1'b0;
    assign inst_size  = 2'b10;
    assign inst_wdata = '0;

    assign room      = (SUM_W'(used_q) + SUM_W'(discard_q)) < SUM_W'(DEPTH);
    assign inst_req  = running_q & (req_hold_q | room);
    assign inst_addr = req_hold_q ? hold_addr_q : fetch_pc_q;
    assign addr_hs   = inst_req & inst_addr_ok;

    assign if_valid = filled_q[head_q];
    assign if_pc    = ent_pc_q[head_q];
    assign if_inst  = ent_inst_q[head_q];

    // A held request made stale by a redirect is accepted without allocating an entry.
    assign alloc_en = addr_hs & ~hold_stale_q & ~redirect_valid;
    assign fill_en  = inst_data_ok & (discard_q == '0) & ~redirect_valid;
    assign retire   = if_valid & if_ready & ~redirect_valid;

    // Allocated-but-unfilled entries become stale responses on a redirect.
    always_comb begin
        filled_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            filled_cnt = filled_cnt + CNT_W'(filled_q[i]);
        end
        unfilled_cnt = used_q - filled_cnt;
    end

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        hold_addr_d  = inst_addr;
        req_hold_d   = inst_req & ~inst_addr_ok;
        hold_stale_d = hold_stale_q & req_hold_d;
        alloc_d      = alloc_q;
        fill_d       = fill_q;
        head_d       = head_q;
        used_d       = used_q;
        discard_d    = discard_q;
        filled_d     = filled_q;

        if (redirect_valid) begin
            alloc_d      = '0;
            fill_d       = '0;
            head_d       = '0;
            used_d       = '0;
            filled_d     = '0;
            fetch_pc_d   = redirect_pc & ~32'h3;
            hold_stale_d = req_hold_d;
            discard_d    = CNT_W'(SUM_W'(discard_q) + SUM_W'(unfilled_cnt)
                                  + SUM_W'(addr_hs) - SUM_W'(inst_data_ok));
        end else begin
            if (alloc_en) begin
                filled_d[alloc_q] = 1'b0;
                alloc_d           = alloc_q + PTR_W'(1);
                fetch_pc_d        = fetch_pc_q + WORD_BYTES;
            end
            if (fill_en) begin
                filled_d[fill_q] = 1'b1;
                fill_d           = fill_q + PTR_W'(1);
            end
            if (retire) begin
                filled_d[head_q] = 1'b0;
                head_d           = head_q + PTR_W'(1);
            end
            used_d    = used_q + CNT_W'(alloc_en) - CNT_W'(retire);
            discard_d = discard_q + CNT_W'(addr_hs & hold_stale_q)
                      - CNT_W'(inst_data_ok & (discard_q != '0));
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            fetch_pc_q   <= RESET_PC;
            hold_addr_q  <= RESET_PC;
            req_hold_q   <= 1'b0;
            hold_stale_q <= 1'b0;
            running_q    <= 1'b0;
            alloc_q      <= '0;
            fill_q       <= '0;
            head_q       <= '0;
            used_q       <= '0;
            discard_q    <= '0;
            filled_q     <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            hold_addr_q  <= hold_addr_d;
            req_hold_q   <= req_hold_d;
            hold_stale_q <= hold_stale_d;
            running_q    <= 1'b1;
            alloc_q      <= alloc_d;
            fill_q       <= fill_d;
            head_q       <= head_d;
            used_q       <= used_d;
            discard_q    <= discard_d;
            filled_q     <= filled_d;
        end
    end

    // Ring payload needs no reset; validity lives in filled_q.
    always_ff @(posedge aclk) begin
        if (alloc_en) begin
            ent_pc_q[alloc_q] <= inst_addr;
        end
        if (fill_en) begin
            ent_inst_q[fill_q] <= inst_rdata;
        end
    end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue with an in-order bridge model
// that answers each accepted address with addr ^ KEY.
module tb_inst_prefetch_queue;

    localparam logic [31:0] KEY = 32'h1234_5678;

    logic        aclk;
    logic        aresetn;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic [31:0] inst_rdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;

    logic        resp_en;
    logic [31:0] q[$];
    int          n_cmp;
    int          n_bad;

    inst_prefetch_queue #(.DEPTH(4), .RESET_PC(32'hbfc00000)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_ready      (if_ready),
        .inst_req      (inst_req),
        .inst_wr       (inst_wr),
        .inst_size     (inst_size),
        .inst_addr     (inst_addr),
        .inst_wdata    (inst_wdata),
        .inst_rdata    (inst_rdata),
        .inst_addr_ok  (inst_addr_ok),
        .inst_data_ok  (inst_data_ok)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // One clock: sample handshakes before the edge, update the bridge model 1ns after it.
    task automatic step();
        logic        hs;
        logic        dok;
        logic [31:0] a;
        hs  = inst_req & inst_addr_ok;
        dok = inst_data_ok;
        a   = inst_addr;
        @(posedge aclk);
        #1;
        if (!aresetn) begin
            q.delete();
            inst_data_ok = 1'b0;
            inst_rdata   = '0;
        end else begin
            if (dok && q.size() > 0) void'(q.pop_front());
            if (hs) q.push_back(a);
            if (resp_en && q.size() > 0) begin
                inst_data_ok = 1'b1;
                inst_rdata   = q[0] ^ KEY;
            end else begin
                inst_data_ok = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        aresetn        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_addr_ok   = 1'b0;
        if_ready       = 1'b0;
        resp_en        = 1'b0;
        step();
        step();
        aresetn = 1'b1;
        step();
    endtask

    task automatic test_reset();
        aresetn        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_addr_ok   = 1'b0;
        if_ready       = 1'b0;
        resp_en        = 1'b0;
        step();
        step();
        n_cmp++; if (inst_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", inst_req); end
        n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", if_valid); end
        n_cmp++; if (inst_wr !== 1'b0 || inst_size !== 2'b10 || inst_wdata !== 32'h0) begin
            n_bad++; $display("FAIL rst_ties: got wr=%b size=%b wdata=%h want 0/10/0", inst_wr, inst_size, inst_wdata);
        end
        aresetn = 1'b1;
        step();
        n_cmp++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00000) begin
            n_bad++; $display("FAIL rst_first_req: got req=%b addr=%h want 1/bfc00000", inst_req, inst_addr);
        end
        n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid_after: got %b want 0", if_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        do_reset();
        inst_addr_ok = 1'b1;
        resp_en      = 1'b1;
        if_ready     = 1'b1;
        step();
        step();
        for (int i = 0; i < 6; i++) begin
            exp_pc = 32'hbfc00000 + 32'(4 * i);
            n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL t1_valid[%0d]: got %b want 1", i, if_valid); end
            n_cmp++; if (if_pc !== exp_pc) begin n_bad++; $display("FAIL t1_pc[%0d]: got %h want %h", i, if_pc, exp_pc); end
            n_cmp++; if (if_inst !== (exp_pc ^ KEY)) begin
                n_bad++; $display("FAIL t1_inst[%0d]: got %h want %h", i, if_inst, exp_pc ^ KEY);
            end
            step();
        end
    endtask

    task automatic test_full();
        int          hs;
        logic [31:0] exp_pc;
        do_reset();
        inst_addr_ok = 1'b1;
        resp_en      = 1'b1;
        if_ready     = 1'b0;
        hs = 0;
        for (int i = 0; i < 10; i++) begin
            if (inst_req && inst_addr_ok) hs++;
            step();
        end
        n_cmp++; if (hs !== 4) begin n_bad++; $display("FAIL t2_hs_count: got %0d want 4", hs); end
        n_cmp++; if (inst_req !== 1'b0) begin n_bad++; $display("FAIL t2_full_req: got %b want 0", inst_req); end
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'hbfc00000) begin
            n_bad++; $display("FAIL t2_head: got v=%b pc=%h want 1/bfc00000", if_valid, if_pc);
        end
        if_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_pc = 32'hbfc00000 + 32'(4 * i);
            n_cmp++; if (if_valid !== 1'b1 || if_pc !== exp_pc) begin
                n_bad++; $display("FAIL t2_drain[%0d]: got v=%b pc=%h want 1/%h", i, if_valid, if_pc, exp_pc);
            end
            if (i == 1) begin
                n_cmp++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00010) begin
                    n_bad++; $display("FAIL t2_resume: got req=%b addr=%h want 1/bfc00010", inst_req, inst_addr);
                end
            end
            step();
        end
    endtask

    task automatic test_redirect_inflight();
        int n;
        bit seen;
        do_reset();
        inst_addr_ok = 1'b1;
        if_ready     = 1'b0;
        resp_en      = 1'b0;
        for (int i = 0; i < 4; i++) step();
        inst_addr_ok = 1'b0;
        n_cmp++; if (inst_req !== 1'b0) begin n_bad++; $display("FAIL t3_full_req: got %b want 0", inst_req); end
        resp_en = 1'b1;
        step();
        step();
        resp_en = 1'b0;
        step();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'hbfc00000) begin
            n_bad++; $display("FAIL t3_pre_head: got v=%b pc=%h want 1/bfc00000", if_valid, if_pc);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80001003;
        step();
        redirect_valid = 1'b0;
        n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL t3_flushed: got %b want 0", if_valid); end
        n_cmp++; if (inst_req !== 1'b1 || inst_addr !== 32'h80001000) begin
            n_bad++; $display("FAIL t3_new_req: got req=%b addr=%h want 1/80001000", inst_req, inst_addr);
        end
        inst_addr_ok = 1'b1;
        resp_en      = 1'b1;
        if_ready     = 1'b1;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (if_valid) seen = 1'b1;
            else begin
                if (inst_data_ok) n++;
                step();
            end
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL t3_timeout: got no if_valid want if_valid within 20 cycles"); end
        n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL t3_dok_before_valid: got %0d want 3", n); end
        n_cmp++; if (if_pc !== 32'h80001000 || if_inst !== (32'h80001000 ^ KEY)) begin
            n_bad++; $display("FAIL t3_first: got pc=%h inst=%h want 80001000/%h", if_pc, if_inst, 32'h80001000 ^ KEY);
        end
        step();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h80001004) begin
            n_bad++; $display("FAIL t3_second: got v=%b pc=%h want 1/80001004", if_valid, if_pc);
        end
    endtask

    task automatic test_redirect_held();
        int n;
        bit seen;
        do_reset();
        inst_addr_ok = 1'b1;
        resp_en      = 1'b1;
        if_ready     = 1'b1;
        for (int i = 0; i < 4; i++) step();
        inst_addr_ok = 1'b0;
        step();
        n_cmp++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00010) begin
            n_bad++; $display("FAIL t4_held: got req=%b addr=%h want 1/bfc00010", inst_req, inst_addr);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80001000;
        step();
        redirect_valid = 1'b0;
        n_cmp++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00010) begin
            n_bad++; $display("FAIL t4_held_after_redirect: got req=%b addr=%h want 1/bfc00010", inst_req, inst_addr);
        end
        n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL t4_flushed: got %b want 0", if_valid); end
        step();
        n_cmp++; if (inst_addr !== 32'hbfc00010) begin
            n_bad++; $display("FAIL t4_held_stable: got %h want bfc00010", inst_addr);
        end
        inst_addr_ok = 1'b1;
        step();
        n_cmp++; if (inst_req !== 1'b1 || inst_addr !== 32'h80001000) begin
            n_bad++; $display("FAIL t4_next_addr: got req=%b addr=%h want 1/80001000", inst_req, inst_addr);
        end
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (if_valid) seen = 1'b1;
            else begin
                if (inst_data_ok) n++;
                step();
            end
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL t4_timeout: got no if_valid want if_valid within 20 cycles"); end
        n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL t4_dok_before_valid: got %0d want 2", n); end
        n_cmp++; if (if_pc !== 32'h80001000 || if_inst !== (32'h80001000 ^ KEY)) begin
            n_bad++; $display("FAIL t4_first: got pc=%h inst=%h want 80001000/%h", if_pc, if_inst, 32'h80001000 ^ KEY);
        end
    endtask

    task automatic test_redirect_coincident();
        int n;
        bit seen;
        do_reset();
        inst_addr_ok = 1'b1;
        resp_en      = 1'b1;
        if_ready     = 1'b1;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80002000;
        step();
        redirect_valid = 1'b0;
        n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL t5_flushed: got %b want 0", if_valid); end
        n_cmp++; if (inst_req !== 1'b1 || inst_addr !== 32'h80002000) begin
            n_bad++; $display("FAIL t5_new_req: got req=%b addr=%h want 1/80002000", inst_req, inst_addr);
        end
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (if_valid) seen = 1'b1;
            else begin
                if (inst_data_ok) n++;
                step();
            end
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL t5_timeout: got no if_valid want if_valid within 20 cycles"); end
        n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL t5_dok_before_valid: got %0d want 2", n); end
        n_cmp++; if (if_pc !== 32'h80002000 || if_inst !== (32'h80002000 ^ KEY)) begin
            n_bad++; $display("FAIL t5_first: got pc=%h inst=%h want 80002000/%h", if_pc, if_inst, 32'h80002000 ^ KEY);
        end
    endtask

    task automatic test_mid_reset();
        bit seen;
        do_reset();
        inst_addr_ok = 1'b1;
        resp_en      = 1'b1;
        if_ready     = 1'b0;
        for (int i = 0; i < 3; i++) step();
        inst_addr_ok = 1'b0;
        for (int i = 0; i < 3; i++) step();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'hbfc00000) begin
            n_bad++; $display("FAIL t6_pre: got v=%b pc=%h want 1/bfc00000", if_valid, if_pc);
        end
        aresetn = 1'b0;
        step();
        n_cmp++; if (if_valid !== 1'b0 || inst_req !== 1'b0) begin
            n_bad++; $display("FAIL t6_in_reset: got v=%b req=%b want 0/0", if_valid, inst_req);
        end
        step();
        aresetn      = 1'b1;
        inst_addr_ok = 1'b1;
        if_ready     = 1'b1;
        step();
        n_cmp++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00000) begin
            n_bad++; $display("FAIL t6_restart: got req=%b addr=%h want 1/bfc00000", inst_req, inst_addr);
        end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (if_valid) seen = 1'b1;
            else step();
        end
        n_cmp++; if (!seen || if_pc !== 32'hbfc00000) begin
            n_bad++; $display("FAIL t6_first: got seen=%b pc=%h want 1/bfc00000", seen, if_pc);
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        inst_rdata   = '0;
        inst_data_ok = 1'b0;
        q.delete();
        test_reset();
        test_stream();
        test_full();
        test_redirect_inflight();
        test_redirect_held();
        test_redirect_coincident();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
